// File: rtl/prbs_sched_pkg.sv
// prbs_sched_pkg: shared definitions for the PRBS code-word scheduler.
//   state_t / ST_*  : controller state encoding (RESEED, WARMUP, RUN)
//   ID_W            : requester-index width for the default requester count
//   SEED_W          : generator seed width
//   seed_sanitize() : maps an all-zero seed onto a fallback seed, because an
//                     LFSR seeded with zero locks up
package prbs_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_RESEED = 2'd0;
  localparam state_t ST_WARMUP = 2'd1;
  localparam state_t ST_RUN    = 2'd2;

  localparam int NUM_REQ_DEF = 4;
  localparam int ID_W        = $clog2(NUM_REQ_DEF);
  localparam int SEED_W      = 11;

  function automatic logic [SEED_W-1:0] seed_sanitize(
    input logic [SEED_W-1:0] seed,
    input logic [SEED_W-1:0] dflt
  );
    return (seed == '0) ? dflt : seed;
  endfunction

endpackage

// File: rtl/prbs_code_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req     in  NUM_REQ  request vector
//   ptr     in  ID_W     highest-priority index for this cycle
//   win_oh  out NUM_REQ  one-hot winner (zero when no request)
//   win_idx out ID_W     winner index
//   any_req out 1        at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [ID_W-1:0]    win_idx,
  output logic               any_req
);

  int unsigned     cand;
  logic [ID_W-1:0] cidx;

  // Scan from ptr upward with wrap; the first set bit wins.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any_req = 1'b0;
    cand    = 0;
    cidx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      cidx = ID_W'(cand);
      if (!any_req && req[cidx]) begin
        any_req      = 1'b1;
        win_idx      = cidx;
        win_oh[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prbs_code_sched.sv
// prbs_code_sched: seed/reset sequencer and round-robin word distributor for
// a free-running parallel PRBS generator.
//   clk, resetb          clock, asynchronous active-low reset
//   cfg_seed, reseed_req seed applied on a reseed pulse (zero -> DEFAULT_SEED)
//   req / gnt            level requests, one-hot single-cycle grants
//   rsp_valid/ready/data/id  registered response slot carrying the granted word
//   busy                 high while not in RUN
//   prbs_rstb, prbs_seed registered reset and seed toward the generator
//   prbs_dat             generator word, used only in RUN
// Optional build macro PRBS_ZERO_GUARD_EN: a zero word in RUN is never granted;
// it forces a reseed with DEFAULT_SEED and sets the sticky zero_err output.
module prbs_code_sched
  import prbs_sched_pkg::*;
#(
  parameter int                        BIT_COUNT      = 16,
  parameter int                        REMAINDER_SIZE = 11,
  parameter int                        NUM_REQ        = 4,
  parameter logic [REMAINDER_SIZE-1:0] DEFAULT_SEED   = 11'h5A5,
  parameter int                        WARMUP_CYCLES  = 2
) (
  input  logic                        clk,
  input  logic                        resetb,
  input  logic [REMAINDER_SIZE-1:0]   cfg_seed,
  input  logic                        reseed_req,
  input  logic [NUM_REQ-1:0]          req,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [BIT_COUNT-1:0]        rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic                        busy,
  output logic                        prbs_rstb,
  output logic [REMAINDER_SIZE-1:0]   prbs_seed,
  input  logic [BIT_COUNT-1:0]        prbs_dat
`ifdef PRBS_ZERO_GUARD_EN
  ,output logic                       zero_err
`endif
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int WW  = $clog2(WARMUP_CYCLES + 1);

  state_t           state;
  state_t           next_state;
  logic [WW-1:0]    warm_cnt;
  logic [IDW-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] win_oh;
  logic [IDW-1:0]   win_idx;
  logic             any_req;
  logic             slot_free;
  logic             zero_hit;
  logic             grant_ok;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (IDW)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any_req (any_req)
  );

  // The slot can take a new word if empty or being drained this cycle.
  assign slot_free = !rsp_valid || rsp_ready;

`ifdef PRBS_ZERO_GUARD_EN
  assign zero_hit = (state == ST_RUN) && any_req && slot_free && (prbs_dat == '0);
`else
  assign zero_hit = 1'b0;
`endif

  // A reseed in the same cycle suppresses the grant.
  assign grant_ok = (state == ST_RUN) && any_req && slot_free && !reseed_req && !zero_hit;

  always_comb begin
    next_state = state;
    case (state)
      ST_RESEED: next_state = ST_WARMUP;
      ST_WARMUP: if (warm_cnt == '0) next_state = ST_RUN;
      ST_RUN:    next_state = ST_RUN;
      default:   next_state = ST_RESEED;
    endcase
    if (reseed_req || zero_hit) next_state = ST_RESEED;
  end

  assign busy = (state != ST_RUN);

  // Controller state, generator reset/seed.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state     <= ST_RESEED;
      warm_cnt  <= '0;
      prbs_rstb <= 1'b0;
      prbs_seed <= DEFAULT_SEED;
    end else begin
      state     <= next_state;
      prbs_rstb <= (next_state != ST_RESEED);
      if (state == ST_RESEED)
        warm_cnt <= WW'(WARMUP_CYCLES - 1);
      else if (state == ST_WARMUP && warm_cnt != '0)
        warm_cnt <= warm_cnt - 1'b1;
      if (reseed_req)
        prbs_seed <= seed_sanitize(cfg_seed, DEFAULT_SEED);
      else if (zero_hit)
        prbs_seed <= DEFAULT_SEED;
    end
  end

  // Grant pulse, round-robin pointer and response slot.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      gnt       <= '0;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      gnt <= grant_ok ? win_oh : '0;
      if (grant_ok) begin
        rsp_valid <= 1'b1;
        rsp_data  <= prbs_dat;
        rsp_id    <= win_idx;
        rr_ptr    <= (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef PRBS_ZERO_GUARD_EN
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)       zero_err <= 1'b0;
    else if (zero_hit) zero_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_prbs_code_sched.sv
// tb_prbs_code_sched: directed-vector bench for prbs_code_sched. The bench
// plays the PRBS generator by driving known prbs_dat values, so each expected
// rsp_data is the word driven in its grant cycle.
module tb_prbs_code_sched;

  logic        clk = 1'b0;
  logic        resetb;
  logic [10:0] cfg_seed;
  logic        reseed_req;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;
  logic        prbs_rstb;
  logic [10:0] prbs_seed;
  logic [15:0] prbs_dat;
`ifdef PRBS_ZERO_GUARD_EN
  logic        zero_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  prbs_code_sched dut (
    .clk        (clk),
    .resetb     (resetb),
    .cfg_seed   (cfg_seed),
    .reseed_req (reseed_req),
    .req        (req),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .prbs_rstb  (prbs_rstb),
    .prbs_seed  (prbs_seed),
    .prbs_dat   (prbs_dat)
`ifdef PRBS_ZERO_GUARD_EN
    ,.zero_err  (zero_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] rr_dat [5] = '{16'hC0DE, 16'h1234, 16'hBEEF, 16'h0F0F, 16'h8001};
  logic [3:0]  rr_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0]  rr_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    resetb = 1'b0; cfg_seed = '0; reseed_req = 1'b0; req = '0;
    rsp_ready = 1'b0; prbs_dat = '0;
    tick(); tick();

    // reset values
    check("rst_rstb",  prbs_rstb, 0);
    check("rst_busy",  busy, 1);
    check("rst_gnt",   gnt, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_data",  rsp_data, 0);
    check("rst_id",    rsp_id, 0);
    check("rst_seed",  prbs_seed, 11'h5A5);
`ifdef PRBS_ZERO_GUARD_EN
    check("rst_zero_err", zero_err, 0);
`endif

    // release: RESEED (1 cycle), WARMUP (2 cycles), then RUN
    resetb = 1'b1;
    #1;
    check("rel_c0_rstb", prbs_rstb, 0);
    check("rel_c0_busy", busy, 1);
    tick();
    check("rel_c1_rstb", prbs_rstb, 1);
    check("rel_c1_busy", busy, 1);
    check("rel_c1_seed", prbs_seed, 11'h5A5);
    tick();
    check("rel_c2_busy", busy, 1);
    tick();
    check("rel_c3_busy", busy, 0);
    check("rel_c3_seed", prbs_seed, 11'h5A5);
    tick();
    check("idle_gnt",   gnt, 0);
    check("idle_valid", rsp_valid, 0);

    // round robin with all requesters active and ready tied high
    req = 4'b1111; rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      prbs_dat = rr_dat[i];
      tick();
      check($sformatf("rr%0d_gnt", i),   gnt, rr_gnt[i]);
      check($sformatf("rr%0d_data", i),  rsp_data, rr_dat[i]);
      check($sformatf("rr%0d_id", i),    rsp_id, rr_id[i]);
      check($sformatf("rr%0d_valid", i), rsp_valid, 1);
    end
    // pointer now 1; a lone req[3] brings it back to 0
    req = 4'b1000; prbs_dat = 16'h7777;
    tick();
    check("r3_gnt", gnt, 4'b1000);
    check("r3_id",  rsp_id, 3);
    check("r3_data", rsp_data, 16'h7777);
    req = 4'b0000;
    tick();
    check("drain_gnt",   gnt, 0);
    check("drain_valid", rsp_valid, 0);

    // backpressure
    rsp_ready = 1'b0; req = 4'b0011; prbs_dat = 16'h5555;
    tick();
    check("bp_gnt",  gnt, 4'b0001);
    check("bp_data", rsp_data, 16'h5555);
    check("bp_id",   rsp_id, 0);
    req = 4'b0010; prbs_dat = 16'hAAAA;
    tick();
    check("bp_hold1_gnt",   gnt, 0);
    check("bp_hold1_valid", rsp_valid, 1);
    check("bp_hold1_data",  rsp_data, 16'h5555);
    check("bp_hold1_id",    rsp_id, 0);
    tick();
    check("bp_hold2_gnt",  gnt, 0);
    check("bp_hold2_data", rsp_data, 16'h5555);
    rsp_ready = 1'b1; prbs_dat = 16'h3C3C;
    tick();
    check("bp_rel_gnt",   gnt, 4'b0010);
    check("bp_rel_data",  rsp_data, 16'h3C3C);
    check("bp_rel_id",    rsp_id, 1);
    check("bp_rel_valid", rsp_valid, 1);
    req = 4'b0000;
    tick();
    check("bp_end_valid", rsp_valid, 0);

    // reseed beats a would-be grant, then reseed again during WARMUP
    req = 4'b0010; reseed_req = 1'b1; cfg_seed = 11'h0AB;
    tick();
    check("rs_gnt",  gnt, 0);
    check("rs_busy", busy, 1);
    check("rs_rstb", prbs_rstb, 0);
    check("rs_seed", prbs_seed, 11'h0AB);
    reseed_req = 1'b0;
    tick();
    check("rs_w1_rstb", prbs_rstb, 1);
    reseed_req = 1'b1; cfg_seed = 11'h123;
    tick();
    check("rsw_rstb", prbs_rstb, 0);
    check("rsw_seed", prbs_seed, 11'h123);
    check("rsw_busy", busy, 1);
    reseed_req = 1'b0;
    tick();
    check("rsw_w1_rstb", prbs_rstb, 1);
    check("rsw_w1_busy", busy, 1);
    tick();
    check("rsw_w2_busy", busy, 1);
    check("rsw_w2_gnt",  gnt, 0);
    tick();
    check("rsw_run_busy", busy, 0);
    check("rsw_run_gnt",  gnt, 0);
    check("rsw_run_seed", prbs_seed, 11'h123);
    prbs_dat = 16'h6161;
    tick();
    check("rsw_g_gnt",  gnt, 4'b0010);
    check("rsw_g_id",   rsp_id, 1);
    check("rsw_g_data", rsp_data, 16'h6161);
    req = 4'b0000;
    tick();
    check("rsw_drain_valid", rsp_valid, 0);

    // reseed with cfg_seed=0 while a response is pending
    rsp_ready = 1'b0; req = 4'b0100; prbs_dat = 16'h9999;
    tick();
    check("pd_gnt", gnt, 4'b0100);
    check("pd_id",  rsp_id, 2);
    req = 4'b0001; reseed_req = 1'b1; cfg_seed = 11'h000;
    tick();
    check("pd_rs_seed",  prbs_seed, 11'h5A5);
    check("pd_rs_rstb",  prbs_rstb, 0);
    check("pd_rs_valid", rsp_valid, 1);
    check("pd_rs_data",  rsp_data, 16'h9999);
    check("pd_rs_id",    rsp_id, 2);
    check("pd_rs_gnt",   gnt, 0);
    reseed_req = 1'b0; rsp_ready = 1'b1;
    tick();
    check("pd_w1_rstb",  prbs_rstb, 1);
    check("pd_w1_valid", rsp_valid, 0);
    check("pd_w1_gnt",   gnt, 0);
    tick();
    check("pd_w2_gnt", gnt, 0);
    tick();
    check("pd_run_busy", busy, 0);
    check("pd_run_gnt",  gnt, 0);
    prbs_dat = 16'h4242;
    tick();
    check("pd_g_gnt",  gnt, 4'b0001);
    check("pd_g_id",   rsp_id, 0);
    check("pd_g_data", rsp_data, 16'h4242);

    // async reset with a pending response
    req = 4'b0000; rsp_ready = 1'b0;
    tick();
    check("ar_pre_valid", rsp_valid, 1);
    #2;
    resetb = 1'b0;
    #1;
    check("ar_valid", rsp_valid, 0);
    check("ar_data",  rsp_data, 0);
    check("ar_busy",  busy, 1);
    check("ar_rstb",  prbs_rstb, 0);
    tick();
    resetb = 1'b1;

`ifdef PRBS_ZERO_GUARD_EN
    tick(); tick(); tick();
    reseed_req = 1'b1; cfg_seed = 11'h0AB;
    tick();
    reseed_req = 1'b0;
    tick(); tick(); tick();
    check("zg_run_busy", busy, 0);
    check("zg_seed_pre", prbs_seed, 11'h0AB);
    req = 4'b0001; rsp_ready = 1'b1; prbs_dat = 16'h0000;
    tick();
    check("zg_gnt",      gnt, 0);
    check("zg_zero_err", zero_err, 1);
    check("zg_seed",     prbs_seed, 11'h5A5);
    check("zg_rstb",     prbs_rstb, 0);
    check("zg_valid",    rsp_valid, 0);
    prbs_dat = 16'h0011;
    tick();
    check("zg_sticky", zero_err, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
